// File: rtl/spi_proto_pkg.sv
// Frame layout, field positions and FSM encoding for the 40-bit stepper SPI protocol.
// Shared by the SPI target RTL and mirrored by firmware headers.
package spi_proto_pkg;

   localparam int unsigned FRAME_SIZE     = 40;
   localparam int unsigned ADDR_BITS      = 7;
   localparam int unsigned STATUS_BITS    = 8;
   localparam int unsigned DATA_BITS      = 32;
   localparam int unsigned WRITE_FLAG_BIT = 39;

   // Bit counter: 40 marks a complete frame, 41 is the sticky overflow marker
   localparam int unsigned CNT_BITS = 6;
   localparam int unsigned CNT_FULL = 40;
   localparam int unsigned CNT_OVF  = 41;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   typedef struct packed {
      logic                 wr;
      logic [ADDR_BITS-1:0] addr;
      logic [DATA_BITS-1:0] data;
   } frame_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with rise/fall pulses
// derived from the synchronised level.
module sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_in,
   input  logic reset_n_in,
   input  logic async_in,
   output logic r_sync_out,
   output logic rise_c,
   output logic fall_c
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign r_sync_out = sync_q;
   assign rise_c     = sync_q & ~prev_q;
   assign fall_c     = ~sync_q & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-3 target emulating a stepper-driver register file; the response to
// each frame carries the status byte and the register addressed by the previous frame.
module spi_target
   import spi_proto_pkg::*;
#(
   parameter int unsigned FRAME_SIZE = 40,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned ERR_WIDTH  = 8
) (
   input  logic                             clk_in,
   input  logic                             reset_n_in,
   input  logic                             sck_in,
   input  logic                             cs_n_in,
   input  logic                             mosi_in,
   input  logic [STATUS_BITS-1:0]           status_in,
   output logic                             r_miso_out,
   output logic                             r_miso_oe_out,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   r_regs_out,
   output logic                             r_write_strobe_out,
   output logic [ADDR_BITS-1:0]             r_write_addr_out,
   output logic [ERR_WIDTH-1:0]             r_frame_err_out
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   logic sck_rise, sck_fall, sck_level_unused;
   logic cs_rise, cs_fall, cs_level_unused;
   logic mosi_level, mosi_rise_unused, mosi_fall_unused;

   sync_edge #(.RESET_VAL(1'b1)) u_sync_sck (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .async_in(sck_in),
      .r_sync_out(sck_level_unused), .rise_c(sck_rise), .fall_c(sck_fall)
   );

   sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .async_in(cs_n_in),
      .r_sync_out(cs_level_unused), .rise_c(cs_rise), .fall_c(cs_fall)
   );

   sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .async_in(mosi_in),
      .r_sync_out(mosi_level), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
   );

   state_t                               state_q, state_d;
   logic [FRAME_SIZE-1:0]                tx_q, rx_q, load_val;
   logic [CNT_BITS-1:0]                  cnt_q;
   logic [ADDR_BITS-1:0]                 read_ptr_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q;
   logic [DATA_WIDTH-1:0]                rd_data;
   frame_t                               frame;
   logic                                 frame_ok, wr_ok;
   logic                                 load_c, drive_c, sample_c, commit_c;

   assign r_regs_out = regs_q;
   assign frame      = frame_t'(rx_q);
   assign frame_ok   = (cnt_q == CNT_BITS'(CNT_FULL));
   assign wr_ok      = frame_ok & frame.wr & (frame.addr < ADDR_BITS'(NUM_REGS));
   assign rd_data    = (read_ptr_q < ADDR_BITS'(NUM_REGS)) ? regs_q[read_ptr_q[IDX_W-1:0]] : '0;
   assign load_val   = {status_in, rd_data};

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cs_fall) state_d = ST_SHIFT;
         ST_SHIFT:  if (cs_rise) state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Per-state datapath controls; a cs_n rise masks any coincident SCK edge
   always_comb begin
      load_c   = 1'b0;
      drive_c  = 1'b0;
      sample_c = 1'b0;
      commit_c = 1'b0;
      case (state_q)
         ST_IDLE:   load_c = cs_fall;
         ST_SHIFT: begin
            drive_c  = sck_fall & ~cs_rise;
            sample_c = sck_rise & ~cs_rise;
         end
         ST_COMMIT: commit_c = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         tx_q               <= '0;
         rx_q               <= '0;
         cnt_q              <= '0;
         read_ptr_q         <= '0;
         regs_q             <= '0;
         r_miso_out         <= 1'b0;
         r_miso_oe_out      <= 1'b0;
         r_write_strobe_out <= 1'b0;
         r_write_addr_out   <= '0;
         r_frame_err_out    <= '0;
      end else begin
         r_write_strobe_out <= 1'b0;
         if (load_c) begin
            tx_q          <= load_val;
            rx_q          <= '0;
            cnt_q         <= '0;
            r_miso_oe_out <= 1'b1;
            r_miso_out    <= load_val[WRITE_FLAG_BIT];
         end
         // Bit index follows the count of rising edges seen so far
         if (drive_c) begin
            r_miso_out <= (cnt_q < CNT_BITS'(CNT_FULL))
                          ? tx_q[CNT_BITS'(WRITE_FLAG_BIT) - cnt_q] : 1'b0;
         end
         if (sample_c) begin
            rx_q <= {rx_q[FRAME_SIZE-2:0], mosi_level};
            if (cnt_q != CNT_BITS'(CNT_OVF)) cnt_q <= cnt_q + CNT_BITS'(1);
         end
         if (commit_c) begin
            r_miso_oe_out <= 1'b0;
            r_miso_out    <= 1'b0;
            if (frame_ok) begin
               read_ptr_q <= frame.addr;
               if (wr_ok) begin
                  regs_q[frame.addr[IDX_W-1:0]] <= frame.data;
                  r_write_strobe_out            <= 1'b1;
                  r_write_addr_out              <= frame.addr;
               end
            end else if (r_frame_err_out != '1) begin
               r_frame_err_out <= r_frame_err_out + ERR_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a mode-3 SPI master issues directed frames,
// and monitors compare captured MISO words and write strobes against queued expectations.
module tb_spi_target;

   localparam int unsigned NUM_REGS   = 16;
   localparam int unsigned DATA_WIDTH = 32;

   logic                           clk_in = 1'b0;
   logic                           reset_n_in = 1'b0;
   logic                           sck_in = 1'b1;
   logic                           cs_n_in = 1'b1;
   logic                           mosi_in = 1'b0;
   logic [7:0]                     status_in = 8'h00;
   logic                           r_miso_out;
   logic                           r_miso_oe_out;
   logic [NUM_REGS*DATA_WIDTH-1:0] r_regs_out;
   logic                           r_write_strobe_out;
   logic [6:0]                     r_write_addr_out;
   logic [7:0]                     r_frame_err_out;

   spi_target #(
      .FRAME_SIZE(40), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ERR_WIDTH(8)
   ) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .sck_in(sck_in), .cs_n_in(cs_n_in),
      .mosi_in(mosi_in), .status_in(status_in), .r_miso_out(r_miso_out),
      .r_miso_oe_out(r_miso_oe_out), .r_regs_out(r_regs_out),
      .r_write_strobe_out(r_write_strobe_out), .r_write_addr_out(r_write_addr_out),
      .r_frame_err_out(r_frame_err_out)
   );

   always #20 clk_in = ~clk_in;

   typedef struct { bit chk; logic [39:0] val; } miso_exp_t;
   typedef struct { logic [6:0] addr; logic [31:0] data; } wr_exp_t;

   miso_exp_t miso_q[$];
   wr_exp_t   wr_q[$];
   int        errors = 0;
   int        checks = 0;
   logic [63:0] cap = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] reg_at(input int k);
      return r_regs_out[k*32 +: 32];
   endfunction

   // MISO monitor: master samples on SCK rise, word compared at cs_n rise
   always @(negedge cs_n_in) cap = '0;
   always @(posedge sck_in) if (cs_n_in === 1'b0) cap = {cap[62:0], r_miso_out};
   always @(posedge cs_n_in) begin
      if (miso_q.size() > 0) begin
         miso_exp_t e;
         e = miso_q.pop_front();
         if (e.chk) check("miso_word", {24'h0, cap[39:0]}, {24'h0, e.val});
      end
   end

   // Write-strobe monitor
   always @(negedge clk_in) begin
      if (r_write_strobe_out === 1'b1) begin
         if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got addr %h expected no strobe", r_write_addr_out);
         end else begin
            wr_exp_t w;
            w = wr_q.pop_front();
            check("strobe_addr", 64'(r_write_addr_out), 64'(w.addr));
            check("strobe_data", 64'(reg_at(int'(w.addr))), 64'(w.data));
         end
      end
   end

   task automatic send_frame(input logic [39:0] word, input int nbits,
                             input logic [39:0] exp, input bit do_chk, input bit exp_wr);
      miso_exp_t m;
      wr_exp_t   w;
      m.chk = do_chk;
      m.val = exp;
      miso_q.push_back(m);
      if (exp_wr) begin
         w.addr = word[38:32];
         w.data = word[31:0];
         wr_q.push_back(w);
      end
      @(negedge clk_in);
      cs_n_in = 1'b0;
      repeat (4) @(negedge clk_in);
      for (int i = 0; i < nbits; i++) begin
         sck_in  = 1'b0;
         mosi_in = (i < 40) ? word[39-i] : 1'b0;
         repeat (5) @(negedge clk_in);
         if (do_chk && i == 0) check("oe_active", 64'(r_miso_oe_out), 64'd1);
         sck_in = 1'b1;
         repeat (5) @(negedge clk_in);
      end
      cs_n_in = 1'b1;
      mosi_in = 1'b0;
      repeat (8) @(negedge clk_in);
      if (do_chk) check("oe_idle", 64'(r_miso_oe_out), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      #1;
      check("rst_miso", 64'(r_miso_out), 64'd0);
      check("rst_oe", 64'(r_miso_oe_out), 64'd0);
      check("rst_regs_zero", 64'(r_regs_out == '0), 64'd1);
      check("rst_strobe", 64'(r_write_strobe_out), 64'd0);
      check("rst_waddr", 64'(r_write_addr_out), 64'd0);
      check("rst_err", 64'(r_frame_err_out), 64'd0);
      @(negedge clk_in);
      reset_n_in = 1'b1;
      repeat (4) @(negedge clk_in);

      // Write reg3 then read it back on the next frame
      status_in = 8'h3C;
      send_frame(40'h83_DEADBEEF, 40, 40'h3C_00000000, 1, 1);
      check("reg3_written", 64'(reg_at(3)), 64'hDEADBEEF);
      send_frame(40'h03_00000000, 40, 40'h3C_DEADBEEF, 1, 0);

      // Pipelined read of reg5
      send_frame(40'h85_12345678, 40, 40'h3C_DEADBEEF, 1, 1);
      status_in = 8'hA5;
      send_frame(40'h05_00000000, 40, 40'hA5_12345678, 1, 0);
      send_frame(40'h00_00000000, 40, 40'hA5_12345678, 1, 0);

      // Out-of-range write: no strobe, pointer goes to 0x7F so data reads as zero
      send_frame(40'hFF_CAFEF00D, 40, 40'hA5_00000000, 1, 0);
      send_frame(40'h00_00000000, 40, 40'hA5_00000000, 1, 0);
      check("oor_reg3", 64'(reg_at(3)), 64'hDEADBEEF);
      check("oor_reg5", 64'(reg_at(5)), 64'h12345678);
      check("oor_reg15", 64'(reg_at(15)), 64'h0);

      // Short and overlong frames count as errors and never write
      send_frame(40'h81_11111111, 39, 40'h0, 0, 0);
      check("err_short", 64'(r_frame_err_out), 64'd1);
      check("short_no_write", 64'(reg_at(1)), 64'h0);
      send_frame(40'h81_22222222, 42, 40'h0, 0, 0);
      check("err_long", 64'(r_frame_err_out), 64'd2);
      check("long_no_write", 64'(reg_at(1)), 64'h0);
      send_frame(40'h00_00000000, 40, 40'hA5_00000000, 1, 0);

      for (int i = 0; i < 253; i++) send_frame(40'h0, 0, 40'h0, 0, 0);
      check("err_at_max", 64'(r_frame_err_out), 64'd255);
      for (int i = 0; i < 45; i++) send_frame(40'h0, 0, 40'h0, 0, 0);
      check("err_saturated", 64'(r_frame_err_out), 64'd255);

      // Reset mid-frame aborts the write and drops oe at once
      begin
         miso_exp_t m;
         logic [39:0] word;
         m.chk = 1'b0;
         m.val = '0;
         miso_q.push_back(m);
         word = 40'h82_0BADF00D;
         @(negedge clk_in);
         cs_n_in = 1'b0;
         repeat (4) @(negedge clk_in);
         for (int i = 0; i < 20; i++) begin
            sck_in  = 1'b0;
            mosi_in = word[39-i];
            repeat (5) @(negedge clk_in);
            sck_in = 1'b1;
            repeat (5) @(negedge clk_in);
         end
         check("oe_before_abort", 64'(r_miso_oe_out), 64'd1);
         reset_n_in = 1'b0;
         #1;
         check("abort_oe", 64'(r_miso_oe_out), 64'd0);
         check("abort_regs_zero", 64'(r_regs_out == '0), 64'd1);
         check("abort_err", 64'(r_frame_err_out), 64'd0);
         cs_n_in = 1'b1;
         mosi_in = 1'b0;
         repeat (3) @(negedge clk_in);
         reset_n_in = 1'b1;
         repeat (4) @(negedge clk_in);
      end
      send_frame(40'h82_00C0FFEE, 40, 40'hA5_00000000, 1, 1);
      check("post_reset_reg2", 64'(reg_at(2)), 64'h00C0FFEE);

      // Firmware-style write/read of reg1
      send_frame(40'h81_000000FF, 40, 40'hA5_00C0FFEE, 1, 1);
      send_frame(40'h01_00000000, 40, 40'hA5_000000FF, 1, 0);
      check("reg1_final", 64'(reg_at(1)), 64'h000000FF);
      check("err_still_zero", 64'(r_frame_err_out), 64'd0);

      repeat (10) @(negedge clk_in);
      check("pending_strobes", 64'(wr_q.size()), 64'd0);
      check("pending_miso", 64'(miso_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
